// File: rtl/seq_divider_param.sv
// seq_divider_param: multi-cycle restoring integer divider, one quotient bit per clock.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//   SIGNED_EN  1: signed_op_i honoured; 0: always unsigned
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start_i        request, accepted only while idle
//   signed_op_i    two's-complement operation, sampled with start_i
//   dividend_i     numerator, sampled with start_i
//   divisor_i      denominator, sampled with start_i
//   busy_o         high whenever the unit is not idle
//   done_o         one-cycle pulse, results valid
//   quotient_o     result quotient (held until the next accepted start)
//   remainder_o    result remainder (held until the next accepted start)
//   div_by_zero_o  divisor was zero (valid with done_o)
module seq_divider_param #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;        // dividend shifts out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             divisor_zero;
  logic             eff_signed;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   partial, diff;
  logic             fits;

  assign accept       = (state_q == StIdle) && start_i;
  assign divisor_zero = (divisor_i == '0);
  assign eff_signed   = SIGNED_EN && signed_op_i;
  assign dvd_neg      = eff_signed && dividend_i[WIDTH-1];
  assign dvs_neg      = eff_signed && divisor_i[WIDTH-1];
  // Most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign dvd_mag      = dvd_neg ? (~dividend_i + One) : dividend_i;
  assign dvs_mag      = dvs_neg ? (~divisor_i + One) : divisor_i;

  // Trial subtraction is one bit wider so the borrow shows up in the MSB.
  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign diff    = partial - {1'b0, dvs_q};
  assign fits    = ~diff[WIDTH];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = divisor_zero ? StDone : StCalc;
      StCalc:  if (cnt_q == '0) state_d = StFixup;
      StFixup: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (divisor_zero) begin
            quot_out_d = '1;
            rem_out_d  = dividend_i;
            dbz_d      = 1'b1;
          end else begin
            rem_d      = '0;
            quo_d      = dvd_mag;
            dvs_d      = dvs_mag;
            cnt_d      = CntW'(WIDTH - 1);
            neg_quo_d  = dvd_neg ^ dvs_neg;
            neg_rem_d  = dvd_neg;
            quot_out_d = '0;
            rem_out_d  = '0;
            dbz_d      = 1'b0;
          end
        end
      end
      StCalc: begin
        rem_d = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        cnt_d = cnt_q - CntW'(1);
      end
      StFixup: begin
        quot_out_d = neg_quo_q ? (~quo_q + One) : quo_q;
        rem_out_d  = neg_rem_q ? (~rem_q + One) : rem_q;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign quotient_o    = quot_out_q;
  assign remainder_o   = rem_out_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Testbench for seq_divider_param: a 32-bit signed-capable instance and an 8-bit unsigned-only
// instance, checked against an arithmetic reference model.
module tb_seq_divider_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, so32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, z32;
  logic [31:0] q32, r32;

  logic        start8 = 1'b0, so8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, z8;
  logic [7:0]  q8, r8;

  seq_divider_param #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start32),
    .signed_op_i  (so32),
    .dividend_i   (a32),
    .divisor_i    (b32),
    .busy_o       (busy32),
    .done_o       (done32),
    .quotient_o   (q32),
    .remainder_o  (r32),
    .div_by_zero_o(z32)
  );

  seq_divider_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start8),
    .signed_op_i  (so8),
    .dividend_i   (a8),
    .divisor_i    (b8),
    .busy_o       (busy8),
    .done_o       (done8),
    .quotient_o   (q8),
    .remainder_o  (r8),
    .div_by_zero_o(z8)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on w-bit values; remainder takes the dividend's sign.
  function automatic void model(input int w, input bit sgn, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output bit z);
    longint mask = (longint'(1) << w) - 1;
    longint sa = longint'(a) & mask;
    longint sb = longint'(b) & mask;
    z = (sb == 0);
    if (z) begin
      q = 32'(mask);
      r = 32'(sa);
      return;
    end
    if (sgn) begin
      if (((sa >> (w - 1)) & 1) != 0) sa -= (longint'(1) << w);
      if (((sb >> (w - 1)) & 1) != 0) sb -= (longint'(1) << w);
    end
    q = 32'((sa / sb) & mask);
    r = 32'((sa % sb) & mask);
  endfunction

  function automatic logic obs_busy(input bit narrow);
    return narrow ? busy8 : busy32;
  endfunction
  function automatic logic obs_done(input bit narrow);
    return narrow ? done8 : done32;
  endfunction
  function automatic logic obs_z(input bit narrow);
    return narrow ? z8 : z32;
  endfunction
  function automatic logic [31:0] obs_q(input bit narrow);
    return narrow ? {24'b0, q8} : q32;
  endfunction
  function automatic logic [31:0] obs_r(input bit narrow);
    return narrow ? {24'b0, r8} : r32;
  endfunction

  // One transaction. disturb_at: cycle index after the start edge at which a second start and
  // a changed dividend are applied. reset_at: cycle index at which reset aborts the operation.
  task automatic run_op(input bit narrow, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int disturb_at, input int reset_at,
                        input string tag);
    int w = narrow ? 8 : 32;
    int lat;
    int dones = 0;
    int first = 0;
    bit busy_ok = 1'b1;
    logic [31:0] eq, er, q_at, r_at;
    bit ez, z_at;
    q_at = '0;
    r_at = '0;
    z_at = 1'b0;
    model(w, narrow ? 1'b0 : sgn, a, b, eq, er, ez);
    lat = ez ? 1 : w + 2;

    @(negedge clk);
    if (narrow) begin
      start8 = 1'b1; so8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; so32 = sgn; a32 = a; b32 = b;
    end

    for (int n = 1; n <= w + 4; n++) begin
      @(negedge clk);
      if (narrow) begin
        start8 = (n == disturb_at);
        if (n == disturb_at) a8 = ~a8;
      end else begin
        start32 = (n == disturb_at);
        if (n == disturb_at) a32 = ~a32;
      end
      if (n == reset_at) begin
        reset = 1'b1;
        #1;
        check({tag, ".rst_busy"}, 32'(obs_busy(narrow)), 32'd0);
        check({tag, ".rst_done"}, 32'(obs_done(narrow)), 32'd0);
        check({tag, ".rst_q"}, obs_q(narrow), 32'd0);
        check({tag, ".rst_r"}, obs_r(narrow), 32'd0);
        check({tag, ".rst_z"}, 32'(obs_z(narrow)), 32'd0);
        @(negedge clk);
        check({tag, ".rst_done2"}, 32'(obs_done(narrow)), 32'd0);
        reset = 1'b0;
        return;
      end
      if (obs_busy(narrow) !== (n <= lat)) busy_ok = 1'b0;
      if (obs_done(narrow) === 1'b1) begin
        dones++;
        if (first == 0) begin
          first = n;
          q_at  = obs_q(narrow);
          r_at  = obs_r(narrow);
          z_at  = obs_z(narrow);
        end
      end
    end

    check({tag, ".latency"}, 32'(first), 32'(lat));
    check({tag, ".ndone"}, 32'(dones), 32'd1);
    check({tag, ".busy"}, 32'(busy_ok), 32'd1);
    check({tag, ".q"}, q_at, eq);
    check({tag, ".r"}, r_at, er);
    check({tag, ".dbz"}, 32'(z_at), 32'(ez));
    check({tag, ".q_hold"}, obs_q(narrow), eq);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.busy32", 32'(busy32), 32'd0);
    check("reset.done32", 32'(done32), 32'd0);
    check("reset.q32", q32, 32'd0);
    check("reset.r32", r32, 32'd0);
    check("reset.z32", 32'(z32), 32'd0);
    check("reset.busy8", 32'(busy8), 32'd0);
    reset = 1'b0;

    run_op(1'b0, 1'b0, 32'd100, 32'd7, 0, 0, "u100_7");
    run_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 0, 0, "s-100_7");
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, 0, 0, "s100_-7");
    run_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 0, 0, "s-100_-7");
    run_op(1'b0, 1'b0, 32'h12345678, 32'd0, 0, 0, "u_dbz");
    run_op(1'b0, 1'b1, 32'h12345678, 32'd0, 0, 0, "s_dbz");
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0, "s_ovf");
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 0, 0, "u_max_1");
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, "u_max_max");
    run_op(1'b0, 1'b0, 32'd1000, 32'd13, 5, 0, "disturb");
    run_op(1'b0, 1'b1, 32'd12345, 32'd67, 0, 10, "abort");
    run_op(1'b0, 1'b1, 32'hFFFFCFC7, 32'd67, 0, 0, "after_abort");

    run_op(1'b1, 1'b0, 32'd200, 32'd3, 0, 0, "w8_200_3");
    run_op(1'b1, 1'b1, 32'd200, 32'd3, 0, 0, "w8_sgn_ignored");
    run_op(1'b1, 1'b0, 32'd77, 32'd0, 0, 0, "w8_dbz");
    run_op(1'b1, 1'b0, 32'd99, 32'd10, 3, 0, "w8_disturb");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom_range(1, 255);
        1: rb = $urandom;
        2: rb = (i % 8 == 2) ? 32'd0 : 32'hFFFFFFFF;
        default: rb = 32'hFFFF0000 | $urandom_range(0, 65535);
      endcase
      rs = 1'($urandom);
      run_op(1'b0, rs, ra, rb, 0, 0, $sformatf("rnd32_%0d", i));
    end

    for (int i = 0; i < 12; i++) begin
      ra = $urandom_range(0, 255);
      rb = (i == 5) ? 32'd0 : $urandom_range(1, 255);
      rs = 1'($urandom);
      run_op(1'b1, rs, ra, rb, 0, 0, $sformatf("rnd8_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised multi-cycle integer divider: restoring algorithm, one quotient bit per clock.
- Successor to the fixed 32-bit unsigned divider. Adds a configurable width, an optional signed mode, a start/busy/done handshake, operand capture, and defined divide-by-zero and overflow results.
- Sits beside the ALU as a long-latency functional unit driven by the execute-stage controller.

Parameters:
- WIDTH, 32: operand and result width in bits (≥ 2).
- SIGNED_EN, 1: 1 = signed_op port honoured; 0 = signed_op ignored, always unsigned.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- signed_op  in  1  1 = two's-complement operation, sampled with start
- dividend  in  WIDTH  numerator, sampled with start
- divisor  in  WIDTH  denominator, sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; results valid
- quotient  out  WIDTH  result quotient
- remainder  out  WIDTH  result remainder
- div_by_zero  out  1  valid with done; divisor was 0

Behaviour:
- Reset: state = IDLE. busy, done, div_by_zero = 0; quotient, remainder = 0; internal registers = 0. Reset asserted mid-operation aborts immediately; no done is produced.
- States: IDLE, CALC, FIXUP, DONE.
- Operand capture:
  - Start accepted only when state = IDLE (start sampled at rising edge T).
  - Operands and the mode are latched at T; later input changes are ignored.
  - start while busy is ignored, with no queuing.
- IDLE → CALC at T+1 when start && divisor != 0.
- IDLE → DONE at T+1 when start && divisor == 0.
- CALC entry (done at T):
  - Convert operands to magnitudes. Negation applies only when the effective signed mode is 1 and the operand MSB is 1.
  - Record neg_q = sign(dividend) XOR sign(divisor).
  - Record neg_r = sign(dividend).
- CALC, each cycle (WIDTH cycles total, T+1 .. T+WIDTH, bit counter WIDTH-1 down to 0):
  - Partial remainder (WIDTH+1 bits) = {rem, next dividend MSB}.
  - Trial subtract the divisor magnitude.
  - Non-negative result → keep the difference; quotient bit = 1.
  - Negative result → restore; quotient bit = 0.
  - CALC → FIXUP after the counter reaches 0.
- FIXUP (T+WIDTH+1):
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Results are truncated toward zero; the remainder sign follows the dividend.
  - FIXUP → DONE.
- DONE (T+WIDTH+2 normally, T+1 for divide-by-zero):
  - done = 1 for exactly this cycle; quotient, remainder, div_by_zero are valid.
  - DONE → IDLE unconditionally.
  - A start asserted during DONE is ignored.
- Latency from the start edge to the done cycle: WIDTH+2 normally; 1 for divide-by-zero.
- quotient, remainder and div_by_zero hold their values from DONE until the next accepted start. They are cleared to 0 at the next CALC entry.
- Divide-by-zero, any mode: quotient = all ones; remainder = dividend; div_by_zero = 1.
- Signed overflow (dividend = most-negative value, divisor = −1): quotient = most-negative value, remainder = 0, no flag. This result falls out naturally of modulo-2^WIDTH magnitude arithmetic.
- Unsigned mode: no sign conversion; FIXUP passes results through unchanged.
- All arithmetic is modulo 2^WIDTH except the WIDTH+1-bit trial subtraction.

Test Plan:
- WIDTH=32, unsigned 100/7 → done at T+34; quotient=14, remainder=2, div_by_zero=0; busy high T+1..T+34.
- Signed −100/7 → quotient=−14 (0xFFFFFFF2), remainder=−2 (0xFFFFFFFE). Signed 100/−7 → quotient=−14, remainder=2.
- Divisor 0, dividend 0x12345678, either mode → done at T+1; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- Second start pulsed mid-CALC and dividend changed after T → both ignored; result matches the original operands; exactly one done pulse.
- Reset asserted at T+10 → busy=0, outputs 0, no done. A fresh start afterwards completes normally. Repeat with WIDTH=8, SIGNED_EN=0: 200/3 → quotient=66, remainder=2 at T+10.
